// File: rtl/nv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nv_ctrl_pkg
//   Shared definitions for the NV controller photon-counting blocks:
//   FSM state encoding of the gated click counter, the minimum synchroniser
//   depth, and a helper that locates a channel field in a flattened bus.
// -----------------------------------------------------------------------------
package nv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int unsigned MIN_SYNC_STAGES = 2;

   // LSB position of channel ch in a bus packing channels of width w.
   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/click_edge_sync.sv
// -----------------------------------------------------------------------------
// click_edge_sync
//   One detector channel: multi-flop synchroniser for the asynchronous click,
//   rising-edge detector, and (with CLICK_DEADTIME_EN defined) a dead-time
//   filter that discards edges for DEADTIME cycles after each counted edge.
//   Configuration macro: CLICK_DEADTIME_EN.
// Ports
//   clk          in  system clock
//   reset        in  synchronous, active-high reset
//   i_click      in  asynchronous detector pulse
//   i_count_en   in  (dead-time build) the emitted edge is being counted
//   i_clear      in  (dead-time build) gate start, clears the dead-time counter
//   o_edge       out one-cycle rising-edge strobe, clk domain
// -----------------------------------------------------------------------------
module click_edge_sync
   import nv_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
`ifdef CLICK_DEADTIME_EN
   , parameter int unsigned DEADTIME  = 4
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic i_click,
`ifdef CLICK_DEADTIME_EN
   input  logic i_count_en,
   input  logic i_clear,
`endif
   output logic o_edge
);

   localparam int unsigned STAGES =
      (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   logic              w_raw_edge;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_click};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign w_raw_edge = r_sync[STAGES-1] & ~r_prev;

`ifdef CLICK_DEADTIME_EN
   localparam int unsigned DT_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);

   logic [DT_W-1:0] r_dt;

   // Only edges that are actually counted arm the hold-off; the counter then
   // blocks the following DEADTIME cycles.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_dt <= '0;
      end else if (o_edge && i_count_en) begin
         r_dt <= DT_W'(DEADTIME);
      end else if (r_dt != '0) begin
         r_dt <= r_dt - 1'b1;
      end
   end

   assign o_edge = w_raw_edge & (r_dt == '0);
`else
   assign o_edge = w_raw_edge;
`endif

endmodule

// File: rtl/gated_click_counter.sv
// -----------------------------------------------------------------------------
// gated_click_counter
//   Multi-channel gated photon-click counter. Clicks are synchronised and
//   edge-detected per channel, rising edges are counted (saturating) during a
//   gate window of gate_cycles clk cycles, and at gate end the counts are
//   snapshotted and held behind a valid/ready handshake.
//   Configuration macro: CLICK_DEADTIME_EN (per-channel dead-time filter).
// Ports
//   clk          in  system clock
//   reset        in  synchronous, active-high reset
//   click        in  [NUM_CH]        asynchronous detector pulses
//   gate_start   in  open a gate window (accepted in IDLE only)
//   gate_cycles  in  [GATE_W]        gate length, 0 treated as 1
//   busy         out gate open or result pending
//   out_valid    out snapshot available
//   out_ready    in  consumer accepts snapshot
//   out_count    out [NUM_CH*CNT_W]  channel i at [i*CNT_W +: CNT_W]
//   out_ovf      out [NUM_CH]        channel saturated during the gate
// -----------------------------------------------------------------------------
module gated_click_counter
   import nv_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned GATE_W      = 24,
   parameter int unsigned SYNC_STAGES = 2
`ifdef CLICK_DEADTIME_EN
   , parameter int unsigned DEADTIME  = 4
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       click,
   input  logic                    gate_start,
   input  logic [GATE_W-1:0]       gate_cycles,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_CH*CNT_W-1:0] out_count,
   output logic [NUM_CH-1:0]       out_ovf
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [GATE_W-1:0]       r_left;
   logic [CNT_W-1:0]        r_cnt     [NUM_CH];
   logic [CNT_W-1:0]        w_cnt_nxt [NUM_CH];
   logic [NUM_CH-1:0]       r_ovf;
   logic [NUM_CH-1:0]       w_ovf_nxt;
   logic [NUM_CH*CNT_W-1:0] w_snap_count;
   logic [NUM_CH*CNT_W-1:0] r_out_count;
   logic [NUM_CH-1:0]       r_out_ovf;
   logic [NUM_CH-1:0]       w_edge;
   logic                    w_start;
   logic                    w_counting;
   logic                    w_last;

   assign w_start    = (r_state == ST_IDLE) && gate_start;
   assign w_counting = (r_state == ST_COUNT);
   assign w_last     = w_counting && (r_left == GATE_W'(1));

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      click_edge_sync #(
         .SYNC_STAGES (SYNC_STAGES)
`ifdef CLICK_DEADTIME_EN
         , .DEADTIME  (DEADTIME)
`endif
      ) u_sync (
         .clk        (clk),
         .reset      (reset),
         .i_click    (click[g]),
`ifdef CLICK_DEADTIME_EN
         .i_count_en (w_counting),
         .i_clear    (w_start),
`endif
         .o_edge     (w_edge[g])
      );
   end

   // Saturating increment; the snapshot bus carries the post-increment values
   // so edges of the final gate cycle are included.
   always_comb begin
      w_snap_count = '0;
      w_ovf_nxt    = r_ovf;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (w_edge[i]) begin
            if (r_cnt[i] == '1) begin
               w_ovf_nxt[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
         w_snap_count[ch_lsb(i, CNT_W) +: CNT_W] = w_cnt_nxt[i];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (gate_start) w_state_nxt = ST_COUNT;
         ST_COUNT: if (w_last)     w_state_nxt = ST_DONE;
         ST_DONE:  if (out_ready)  w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_left      <= '0;
         r_ovf       <= '0;
         r_out_count <= '0;
         r_out_ovf   <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_left <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
            r_ovf  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
               r_cnt[i] <= '0;
            end
         end else if (w_counting) begin
            r_left <= r_left - 1'b1;
            r_ovf  <= w_ovf_nxt;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
               r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_last) begin
               r_out_count <= w_snap_count;
               r_out_ovf   <= w_ovf_nxt;
            end
         end
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign out_count = r_out_count;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_gated_click_counter.sv
module tb_gated_click_counter;

   localparam int NUM_CH      = 2;
   localparam int CNT_W       = 4;
   localparam int GATE_W      = 24;
   localparam int SYNC_STAGES = 2;
   localparam int DEADTIME    = 4;
   localparam int HIST_N      = 16384;
`ifdef CLICK_DEADTIME_EN
   localparam bit DT_ON = 1'b1;
`else
   localparam bit DT_ON = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NUM_CH-1:0]       click = '0;
   logic                    gate_start = 1'b0;
   logic [GATE_W-1:0]       gate_cycles = '0;
   logic                    busy;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [NUM_CH*CNT_W-1:0] out_count;
   logic [NUM_CH-1:0]       out_ovf;

   always #5 clk = ~clk;

   gated_click_counter #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .GATE_W      (GATE_W),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef CLICK_DEADTIME_EN
      , .DEADTIME  (DEADTIME)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .click       (click),
      .gate_start  (gate_start),
      .gate_cycles (gate_cycles),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_count   (out_count),
      .out_ovf     (out_ovf)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model: a gate is a window of len clock edges after the accepting
   // edge; a click first sampled high at edge k (after a low sample) is an edge
   // seen at clock edge k+SYNC_STAGES.
   logic [NUM_CH-1:0] hist [HIST_N];
   int  m_phase = 0;             // 0 idle, 1 gate open, 2 result held
   int  m_rem   = 0;
   int  m_cnt     [NUM_CH];
   bit  m_ovf     [NUM_CH];
   int  m_out     [NUM_CH];
   bit  m_out_ovf [NUM_CH];
   int  m_lastc   [NUM_CH];

   always @(posedge clk) begin
      int p;
      cyc++;
      p = cyc;
      if (p < HIST_N) hist[p] = reset ? '0 : click;
      if (reset) begin
         m_phase = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_out[i] = 0; m_out_ovf[i] = 0; m_lastc[i] = -1000;
         end
      end else if (m_phase == 0) begin
         if (gate_start) begin
            m_rem   = (gate_cycles == 0) ? 1 : int'(gate_cycles);
            m_phase = 1;
            for (int i = 0; i < NUM_CH; i++) begin
               m_cnt[i] = 0; m_ovf[i] = 0; m_lastc[i] = -1000;
            end
         end
      end else if (m_phase == 1) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (p > SYNC_STAGES + 1 && p < HIST_N &&
                hist[p-SYNC_STAGES][i] && !hist[p-SYNC_STAGES-1][i] &&
                (!DT_ON || (p - m_lastc[i] > DEADTIME))) begin
               m_lastc[i] = p;
               if (m_cnt[i] == (1 << CNT_W) - 1) m_ovf[i] = 1;
               else m_cnt[i]++;
            end
         end
         m_rem--;
         if (m_rem == 0) begin
            m_phase = 2;
            for (int i = 0; i < NUM_CH; i++) begin
               m_out[i] = m_cnt[i]; m_out_ovf[i] = m_ovf[i];
            end
         end
      end else begin
         if (out_ready) m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("busy", busy, m_phase != 0);
         chk("out_valid", out_valid, m_phase == 2);
         for (int i = 0; i < NUM_CH; i++) begin
            chk("out_count", out_count[i*CNT_W +: CNT_W], m_out[i]);
            chk("out_ovf", out_ovf[i], m_out_ovf[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulses(input logic [NUM_CH-1:0] mask, input int n, input int hi, input int lo);
      for (int k = 0; k < n; k++) begin
         click = click | mask;
         repeat (hi) tick();
         click = click & ~mask;
         repeat (lo) tick();
      end
   endtask

   task automatic start_gate(input int len);
      gate_cycles = GATE_W'(len);
      gate_start  = 1'b1;
      tick();
      gate_start  = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 400) begin
         tick();
         n++;
      end
      if (!out_valid) chk("valid_timeout", out_valid, 1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int n0;
      hist[0] = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_count", out_count, 0);
      chk("rst_ovf", out_ovf, 0);

      // 1: 10 clicks ch0, 3 on ch1, gate of 100
      n0 = cyc;
      start_gate(100);
      fork
         pulses(2'b01, 10, 3, 3);
         pulses(2'b10, 3, 3, 3);
      join
      wait_valid();
      chk("t1_latency", cyc - n0, 101);
      chk("t1_ch0", out_count[3:0], 10);
      chk("t1_ch1", out_count[7:4], 3);
      chk("t1_ovf", out_ovf, 0);
      consume();

      // 2: clicks outside the window; edge on last gate cycle vs one after
      pulses(2'b11, 3, 3, 3);
      repeat (6) tick();
      start_gate(20);
      repeat (17) tick();
      click[0] = 1'b1;
      tick();
      click[1] = 1'b1;
      repeat (2) tick();
      click = '0;
      wait_valid();
      chk("t2_last_cycle_edge", out_count[3:0], 1);
      chk("t2_after_gate_edge", out_count[7:4], 0);
      consume();
      repeat (4) tick();
      n0 = cyc;
      start_gate(0);
      wait_valid();
      chk("t2_zero_len_latency", cyc - n0, 2);
      chk("t2_zero_len_count", out_count, 0);
      consume();

      // 3: saturation on ch0 only
      start_gate(150);
      pulses(2'b01, 20, 3, 3);
      wait_valid();
      chk("t3_sat_count", out_count[3:0], 15);
      chk("t3_ch1", out_count[7:4], 0);
      chk("t3_ovf", out_ovf, 2'b01);

      // 4: held in DONE, gate_start and clicks ignored
      repeat (5) tick();
      gate_start = 1'b1; gate_cycles = 24'd7;
      tick();
      gate_start = 1'b0;
      pulses(2'b11, 5, 3, 3);
      repeat (14) tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_count", out_count[3:0], 15);
      chk("t4_hold_ovf", out_ovf, 2'b01);
      consume();
      chk("t4_idle", busy, 0);
      start_gate(5);
      chk("t4_new_gate", busy, 1);
      wait_valid();
      consume();

      // 5: reset mid-gate
      start_gate(100);
      pulses(2'b01, 4, 3, 3);
      reset = 1'b1;
      tick();
      chk("t5_busy", busy, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_count", out_count, 0);
      reset = 1'b0;
      tick();
      start_gate(40);
      pulses(2'b10, 2, 3, 3);
      wait_valid();
      chk("t5_ch1", out_count[7:4], 2);
      chk("t5_ch0", out_count[3:0], 0);
      consume();

      // 6: closely spaced clicks (dead-time filter when built)
      start_gate(60);
      fork
         pulses(2'b01, 6, 2, 1);
         pulses(2'b10, 4, 2, 2);
      join
      wait_valid();
      chk("t6_ch0", out_count[3:0], DT_ON ? 3 : 6);
      chk("t6_ch1", out_count[7:4], DT_ON ? 2 : 4);
      consume();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
